dice_ram_fifo_ctrl: RTL

//  Initiator side of a dice_ram 1W1R RAM: a valid/ready FIFO controller driving an external 1W1R RAM.

---
 rtl/dice_ram_pkg.sv | 10 +
 rtl/dice_ram_1w1r.sv | 20 ++
 rtl/dice_ram_fifo_obuf.sv | 34 +++
 rtl/dice_ram_fifo_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/dice_ram_pkg.sv
// dice_ram_pkg: shared status type and output-buffer sizing for the dice_ram FIFO controller
package dice_ram_pkg;
  localparam int OBUF_DEPTH = 2;
  localparam int OBUF_CW = $clog2(OBUF_DEPTH + 1);
  typedef struct packed {
    logic [31:0] count;
    logic        full;
    logic        empty;
  } ram_fifo_status_t;
endpackage

// File: rtl/dice_ram_1w1r.sv
// dice_ram_1w1r: one-write one-read RAM with a registered (1-cycle) read port
module dice_ram_1w1r #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/dice_ram_fifo_obuf.sv
// dice_ram_fifo_obuf: 2-entry capture/pop buffer holding RAM read returns in front of the consumer
module dice_ram_fifo_obuf
  import dice_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  pop,
  output logic [OBUF_CW-1:0]    cnt,
  output logic [DATA_WIDTH-1:0] head
);
  logic [DATA_WIDTH-1:0] tail, head_n, tail_n;
  logic [OBUF_CW-1:0] cnt_n;
  always_comb begin
    head_n = pop ? (cap && cnt == 1 ? cap_data : tail) : (cap && cnt == 0 ? cap_data : head);
    tail_n = cap && (pop ? cnt == OBUF_CW'(OBUF_DEPTH) : cnt != '0) ? cap_data : tail;
    cnt_n = cnt + OBUF_CW'(cap) - OBUF_CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      cnt <= flush ? '0 : cnt_n;
      head <= head_n;
      tail <= tail_n;
    end
  end
endmodule

// File: rtl/dice_ram_fifo_ctrl.sv
// dice_ram_fifo_ctrl: valid/ready FIFO controller over an external 1W1R RAM with a 2-entry output buffer
module dice_ram_fifo_ctrl
  import dice_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [DATA_WIDTH-1:0]  push_data,
  output logic                   pop_valid,
  input  logic                   pop_ready,
  output logic [DATA_WIDTH-1:0]  pop_data,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   ram_wr_en,
  output logic [ADDR_WIDTH-1:0]  ram_wr_addr,
  output logic [DATA_WIDTH-1:0]  ram_wr_data,
  output logic                   ram_rd_en,
  output logic [ADDR_WIDTH-1:0]  ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]  ram_rd_data
);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [COUNT_WIDTH-1:0] ram_cnt;
  logic inflight, push_fire, pop_fire;
  logic [OBUF_CW-1:0] obuf_cnt;
  logic [OBUF_CW:0] occ;
  ram_fifo_status_t st;
  always_comb begin
    st = '{count: 32'(count), full: count == COUNT_WIDTH'(DEPTH), empty: count == '0};
    push_ready = !flush && !st.full;
    pop_valid = !flush && obuf_cnt != '0;
    push_fire = push_valid && push_ready;
    pop_fire = pop_valid && pop_ready;
    occ = (OBUF_CW + 1)'(obuf_cnt) + (OBUF_CW + 1)'(inflight) - (OBUF_CW + 1)'(pop_fire);
    ram_rd_en = !flush && ram_cnt != '0 && occ < (OBUF_CW + 1)'(OBUF_DEPTH);
    ram_wr_en = push_fire;
    ram_wr_addr = wr_ptr;
    ram_wr_data = push_data;
    ram_rd_addr = rd_ptr;
  end
  // ram_cnt is registered only, so a word is never read in the cycle it is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ram_cnt <= '0;
      count <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ram_cnt <= '0;
      count <= '0;
      inflight <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_WIDTH'(push_fire);
      rd_ptr <= rd_ptr + ADDR_WIDTH'(ram_rd_en);
      ram_cnt <= ram_cnt + COUNT_WIDTH'(push_fire) - COUNT_WIDTH'(ram_rd_en);
      count <= count + COUNT_WIDTH'(push_fire) - COUNT_WIDTH'(pop_fire);
      inflight <= ram_rd_en;
    end
  end
  dice_ram_fifo_obuf #(.DATA_WIDTH(DATA_WIDTH)) u_obuf (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .cap(inflight),
    .cap_data(ram_rd_data),
    .pop(pop_fire),
    .cnt(obuf_cnt),
    .head(pop_data)
  );
  a_count: assert property (@(posedge clk) disable iff (!rst_n)
    st.count == 32'(ram_cnt) + 32'(inflight) + 32'(obuf_cnt));
  a_rd_empty: assert property (@(posedge clk) disable iff (!rst_n) !(ram_rd_en && ram_cnt == '0));
  a_collide: assert property (@(posedge clk) disable iff (!rst_n)
    !(ram_rd_en && ram_wr_en && ram_rd_addr == ram_wr_addr));
  a_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_valid && st.empty));
endmodule
